// File: rtl/test_memory_nport.sv
// N-port behavioural test memory: per-port IDLE/STALL handshake FSM with zero,
// fixed or LFSR-random latency, sticky protocol-error flags and backdoor access.
module test_memory_nport #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned STALL_MODE = 0,
  parameter int unsigned MAX_WAIT   = 3,
  parameter logic [15:0] SEED       = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_PORTS-1:0]    mem_val,
  output logic [NUM_PORTS-1:0]    mem_wait,
  input  logic [NUM_PORTS-1:0]    mem_type,
  input  logic [32*NUM_PORTS-1:0] mem_addr,
  input  logic [32*NUM_PORTS-1:0] mem_wdata,
  output logic [32*NUM_PORTS-1:0] mem_rdata,
  output logic [NUM_PORTS-1:0]    mem_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = 4;

  typedef enum logic {S_IDLE, S_STALL} state_e;

  typedef struct packed {
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic [31:0]          mem_q [DEPTH];
  logic [15:0]          lfsr_q, lfsr_d;
  state_e               state_q [NUM_PORTS];
  state_e               state_d [NUM_PORTS];
  logic [CW-1:0]        cnt_q   [NUM_PORTS];
  logic [CW-1:0]        cnt_d   [NUM_PORTS];
  req_t                 req_q   [NUM_PORTS];
  req_t                 req_d   [NUM_PORTS];
  req_t                 req_c   [NUM_PORTS];
  logic [CW-1:0]        dly_c   [NUM_PORTS];
  logic [AW-1:0]        idx_c   [NUM_PORTS];
  logic [NUM_PORTS-1:0] err_q, err_d;
  logic [NUM_PORTS-1:0] stall_c, done_c;

  // Backdoor write channel: the task toggles bd_tog, the array commits on the next edge
  logic [AW-1:0]        bd_idx;
  logic [31:0]          bd_data;
  logic                 bd_tog;
  logic                 bd_seen_q;

  function automatic logic [AW-1:0] word_idx(input logic [31:0] addr);
    return AW'(addr >> 2);
  endfunction

  task automatic write(input logic [31:0] addr, input logic [31:0] data);
    bd_idx  = word_idx(addr);
    bd_data = data;
    bd_tog  = ~bd_tog;
  endtask

  function automatic logic [31:0] read(input logic [31:0] addr);
    return mem_q[word_idx(addr)];
  endfunction

  // 16-bit Fibonacci LFSR, taps 16,14,13,11
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Per-port latency selection, request capture and handshake FSM
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      req_c[p].typ   = mem_type[p];
      req_c[p].addr  = mem_addr[32*p +: 32];
      req_c[p].wdata = mem_wdata[32*p +: 32];
      idx_c[p]       = word_idx(mem_addr[32*p +: 32]);
      dly_c[p]       = '0;
      if (STALL_MODE == 1) begin
        dly_c[p] = CW'(MAX_WAIT);
      end else if (STALL_MODE == 2) begin
        dly_c[p] = CW'({1'b0, lfsr_q[4*p +: 4]} % 5'(MAX_WAIT + 1));
      end

      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      req_d[p]   = req_q[p];
      err_d[p]   = err_q[p];
      stall_c[p] = 1'b0;
      done_c[p]  = 1'b0;

      case (state_q[p])
        S_IDLE: begin
          if (mem_val[p]) begin
            if (dly_c[p] != '0) begin
              stall_c[p] = 1'b1;
              state_d[p] = S_STALL;
              cnt_d[p]   = dly_c[p] - CW'(1);
              req_d[p]   = req_c[p];
            end else begin
              done_c[p] = rst;
            end
          end
        end
        S_STALL: begin
          if (!mem_val[p]) begin
            // Abandoned request: abort without touching memory
            state_d[p] = S_IDLE;
            cnt_d[p]   = '0;
            err_d[p]   = 1'b1;
          end else begin
            if (req_c[p] != req_q[p]) begin
              err_d[p] = 1'b1;
            end
            if (cnt_q[p] != '0) begin
              stall_c[p] = 1'b1;
              cnt_d[p]   = cnt_q[p] - CW'(1);
            end else begin
              done_c[p]  = rst;
              state_d[p] = S_IDLE;
            end
          end
        end
        default: begin
          state_d[p] = S_IDLE;
        end
      endcase
    end
  end

  // Stall is suppressed while reset is asserted
  always_comb begin
    mem_wait = stall_c & {NUM_PORTS{rst}};
    mem_err  = err_q;
  end

  // Read data is only driven in a completing read cycle
  always_comb begin
    mem_rdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (done_c[p] && !mem_type[p]) begin
        mem_rdata[32*p +: 32] = mem_q[idx_c[p]];
      end
    end
  end

  // Storage array is never reset; ascending port order lets the highest port win
  always_ff @(posedge clk) begin
    bd_seen_q <= bd_tog;
    if (bd_tog != bd_seen_q) begin
      mem_q[bd_idx] <= bd_data;
    end
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (done_c[p] && mem_type[p]) begin
        mem_q[idx_c[p]] <= mem_wdata[32*p +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
      err_q  <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= S_IDLE;
        cnt_q[p]   <= '0;
        req_q[p]   <= '0;
      end
    end else begin
      lfsr_q <= lfsr_d;
      err_q  <= err_d;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        req_q[p]   <= req_d[p];
      end
    end
  end

endmodule
